data_mem_access_unit: RTL and testbench

- Load/store unit sitting directly downstream of the multicycle core's data-memory path, on its data side.
- Takes one 64-bit load/store request at a time (address, size, sign, write data) and performs it on a 32-bit data memory that uses a req/ack handshake.
- Handles byte/half/word/double sizing, lane selection, write byte-enables, sign/zero extension and two-beat doubleword splitting.
- Reports misalignment and memory timeouts as errors.

---
 rtl/data_mem_access_unit_if.sv | 44 ++++
 rtl/data_mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_if.sv
// Bus bundle for data_mem_access_unit: core request/response side and
// 32-bit data memory beat side (req/ack).
//   req_*  : core -> unit request (valid/ready handshake)
//   rsp_*  : unit -> core one-cycle response pulse
//   mem_*  : unit <-> memory beat handshake (req held until ack)
// slave  : seen from the unit
// master : seen from the core/memory environment
interface data_mem_access_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [63:0]       req_wdata;

    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store unit: one 64-bit load/store at a time performed on a 32-bit
// req/ack data memory, with lane selection, byte enables, extension,
// two-beat doubleword split, misalignment and beat-timeout errors.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : data_mem_access_unit_if.slave (req_*, rsp_*, mem_*)
module data_mem_access_unit #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    data_mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last count value at which a beat may still be acked.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;

    logic              we_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [63:0]       wdata_q;
    logic [31:0]       low_q;
    logic [15:0]       cnt_q;
    logic [63:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              aligned;
    logic              in_beat;
    logic              last_beat;
    logic              timed_out;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        be0;
    logic [31:0]       wdata0;
    logic [63:0]       load_val;

    function automatic logic [63:0] extract(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] sh;
        logic [63:0] v;
        sh = w >> {lane, 3'b000};
        unique case (size)
            2'b00:   v = sgn ? {{56{sh[7]}}, sh[7:0]}
                         : {56'd0, sh[7:0]};
            2'b01:   v = sgn ? {{48{sh[15]}}, sh[15:0]}
                         : {48'd0, sh[15:0]};
            default: v = sgn ? {{32{sh[31]}}, sh}
                         : {32'd0, sh};
        endcase
        return v;
    endfunction

    assign accept  = (state == IDLE) && bus.req_valid;
    assign in_beat = (state == BEAT0) || (state == BEAT1);

    always_comb begin
        unique case (bus.req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.req_addr[0];
            2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
            default: aligned = (bus.req_addr[2:0] == 3'b000);
        endcase
    end

    assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign last_beat = (state == BEAT1) || (size_q != 2'b11);
    // Ack in the same cycle as the final count wins over timeout.
    assign timed_out = in_beat && !bus.mem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        unique case (size_q)
            2'b00: begin
                be0    = 4'b0001 << addr_q[1:0];
                wdata0 = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be0    = 4'b0011 << addr_q[1:0];
                wdata0 = {2{wdata_q[15:0]}};
            end
            default: begin
                be0    = 4'b1111;
                wdata0 = wdata_q[31:0];
            end
        endcase
    end

    always_comb begin
        if (we_q) begin
            load_val = 64'd0;
        end else if (state == BEAT1) begin
            load_val = {bus.mem_rdata, low_q};
        end else begin
            load_val = extract(bus.mem_rdata, addr_q[1:0], size_q, signed_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'd0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nx = aligned ? BEAT0 : RESP;
                end
            end
            BEAT0: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_addr;
                bus.mem_be    = be0;
                bus.mem_wdata = wdata0;
                if (bus.mem_ack) begin
                    state_nx = (size_q == 2'b11) ? BEAT1 : RESP;
                end else if (timed_out) begin
                    state_nx = RESP;
                end
            end
            BEAT1: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_addr + ADDR_W'(4);
                bus.mem_be    = 4'b1111;
                bus.mem_wdata = wdata_q[63:32];
                if (bus.mem_ack || timed_out) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            wdata_q  <= 64'd0;
            low_q    <= 32'd0;
            cnt_q    <= 16'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                size_q   <= bus.req_size;
                wdata_q  <= bus.req_wdata;
            end

            // Each beat starts counting from zero.
            if (state == IDLE) begin
                cnt_q <= 16'd0;
            end else if (in_beat) begin
                cnt_q <= bus.mem_ack ? 16'd0 : cnt_q + 16'd1;
            end

            if ((state == BEAT0) && bus.mem_ack) begin
                low_q <= bus.mem_rdata;
            end

            // Response registers change only when a new response is formed.
            if (accept && !aligned) begin
                rdata_q <= 64'd0;
                err_q   <= 1'b1;
            end else if (in_beat && bus.mem_ack && last_beat) begin
                rdata_q <= load_val;
                err_q   <= 1'b0;
            end else if (timed_out) begin
                rdata_q <= 64'd0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: request-level model,
// per-cycle compare process, and directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_data_mem_access_unit;

    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_access_unit_if #(.ADDR_W(64)) bus ();
    data_mem_access_unit_if #(.ADDR_W(64)) t_bus ();

    data_mem_access_unit #(.ADDR_W(64), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_access_unit #(.ADDR_W(64), .TIMEOUT(4)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (t_bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] phys [logic [63:0]];
    int d [2];

    // Model state of the transaction in flight.
    logic        act = 1'b0;
    logic        done = 1'b0;
    logic        m_we, m_sgn, m_mis;
    logic [63:0] m_addr, m_wd;
    logic [1:0]  m_size;
    int          m_nb, m_t, m_exp_cyc, m_gap, lat;
    int          last_rsp = -100;
    logic [63:0] m_exp_rdata;
    logic        m_exp_err;
    int          mreq_cyc;
    int          bidx = 0;
    int          wcnt = 0;
    logic [63:0] log_addr [2];
    logic [31:0] log_wd [2];
    logic [3:0]  log_be [2];
    logic [63:0] got_rdata;
    logic        got_err;
    int          got_lat;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act_v,
                       input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [31:0] phys_rd(input logic [63:0] a);
        if (phys.exists(a)) return phys[a];
        return 32'd0;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    // Byte k of beat i is enabled when its address lies inside the access.
    function automatic logic [3:0] exp_be(input logic [63:0] a,
                                         input logic [1:0] s, input int i);
        logic [63:0] base, b;
        logic [3:0]  be;
        int n;
        n = nbytes(s);
        base = (a & ~64'd3) + 64'(4 * i);
        be = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            b = base + 64'(k);
            be[k] = (b >= a) && (b < a + 64'(n));
        end
        return be;
    endfunction

    // Store data repeats with the access size across each beat.
    function automatic logic [31:0] exp_wd(input logic [63:0] wd,
                                           input logic [1:0] s, input int i);
        logic [31:0] w;
        logic [63:0] sh;
        int n;
        n = nbytes(s);
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            sh = wd >> (8 * ((4 * i + k) % n));
            w[8*k +: 8] = sh[7:0];
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] a,
                                             input logic [1:0] s,
                                             input logic sg);
        logic [63:0] v, b;
        logic [31:0] wrd;
        int n;
        n = nbytes(s);
        v = 64'd0;
        for (int j = 0; j < n; j++) begin
            b = a + 64'(j);
            wrd = phys_rd(b & ~64'd3) >> (8 * int'(b[1:0]));
            v = v | (64'(wrd[7:0]) << (8 * j));
        end
        if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) bidx = 0;
        else if (bus.req_valid && bus.req_ready) bidx = 0;
        else if (bus.mem_req && bus.mem_ack) bidx = bidx + 1;
    end

    // Memory responder with per-beat wait counts.
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (reset && bus.mem_req) begin
            if (wcnt >= d[(bidx > 1) ? 1 : bidx]) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = phys_rd(bus.mem_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (!reset) begin
            act = 1'b0;
        end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(!act));
            chk("mem_req", 64'(bus.mem_req),
                64'(act && !m_mis && bidx < m_nb));
            if (bus.mem_req && act && !m_mis && bidx < m_nb) begin
                chk("mem_we", 64'(bus.mem_we), 64'(m_we));
                chk("mem_addr", bus.mem_addr,
                    (m_addr & ~64'd3) + 64'(4 * bidx));
                chk("mem_be", 64'(bus.mem_be), 64'(exp_be(m_addr, m_size, bidx)));
                chk("mem_wdata", 64'(bus.mem_wdata),
                    64'(exp_wd(m_wd, m_size, bidx)));
                log_addr[bidx] = bus.mem_addr;
                log_wd[bidx] = bus.mem_wdata;
                log_be[bidx] = bus.mem_be;
                mreq_cyc++;
            end
            if (bus.rsp_valid) begin
                chk("rsp_expected", 64'(act), 64'd1);
                if (act) begin
                    chk("rsp_cycle", 64'(cyc), 64'(m_exp_cyc));
                    chk("rsp_rdata", bus.rsp_rdata, m_exp_rdata);
                    chk("rsp_err", 64'(bus.rsp_err), 64'(m_exp_err));
                    got_rdata = bus.rsp_rdata;
                    got_err = bus.rsp_err;
                    got_lat = cyc - m_t;
                    last_rsp = cyc;
                    act = 1'b0;
                    done = 1'b1;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                m_t = cyc;
                m_gap = m_t - last_rsp;
                m_we = bus.req_we;
                m_addr = bus.req_addr;
                m_size = bus.req_size;
                m_sgn = bus.req_signed;
                m_wd = bus.req_wdata;
                m_nb = (m_size == 2'b11) ? 2 : 1;
                m_mis = (m_addr & 64'(nbytes(m_size) - 1)) != 64'd0;
                m_exp_err = m_mis;
                lat = 1;
                if (!m_mis) begin
                    for (int i = 0; i < m_nb; i++) begin
                        if (!m_exp_err) begin
                            if (d[i] >= TO) begin
                                lat += TO;
                                m_exp_err = 1'b1;
                            end else begin
                                lat += d[i] + 1;
                            end
                        end
                    end
                end
                m_exp_cyc = m_t + lat;
                m_exp_rdata = (m_exp_err || m_we) ? 64'd0
                            : exp_load(m_addr, m_size, m_sgn);
                mreq_cyc = 0;
                act = 1'b1;
                done = 1'b0;
            end
        end
    end

    // Call at a posedge; returns at the posedge the unit is idle again.
    task automatic do_req(input logic we, input logic [63:0] a,
                          input logic [1:0] s, input logic sg,
                          input logic [63:0] wd, input int d0, input int d1);
        int n;
        d[0] = d0;
        d[1] = d1;
        #1;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_addr = a;
        bus.req_size = s;
        bus.req_signed = sg;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (!done) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic t_run(input int ack_at, output int n, output logic got,
                         output logic err, output logic [63:0] rd);
        @(posedge clk);
        #1;
        t_bus.req_valid = 1'b1;
        t_bus.req_we = 1'b0;
        t_bus.req_addr = 64'h40;
        t_bus.req_size = 2'b10;
        t_bus.req_signed = 1'b0;
        t_bus.req_wdata = 64'd0;
        @(posedge clk);
        #1;
        t_bus.req_valid = 1'b0;
        n = 0;
        got = 1'b0;
        err = 1'b0;
        rd = 64'd0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            t_bus.mem_ack = 1'b0;
            if (t_bus.rsp_valid) begin
                got = 1'b1;
                err = t_bus.rsp_err;
                rd = t_bus.rsp_rdata;
            end else if (t_bus.mem_req) begin
                n++;
                if (n == ack_at) begin
                    t_bus.mem_ack = 1'b1;
                    t_bus.mem_rdata = 32'h12345678;
                end
            end
        end
    endtask

    int          tn;
    logic        tgot, terr;
    logic [63:0] trd;

    initial begin
        d[0] = 0;
        d[1] = 0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 64'd0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_wdata = 64'd0;
        t_bus.req_valid = 1'b0;
        t_bus.req_we = 1'b0;
        t_bus.req_addr = 64'd0;
        t_bus.req_size = 2'b00;
        t_bus.req_signed = 1'b0;
        t_bus.req_wdata = 64'd0;
        t_bus.mem_ack = 1'b0;
        t_bus.mem_rdata = 32'd0;
        phys[64'h1000] = 32'h80AABBCC;
        phys[64'h0100] = 32'hF00D0000;
        phys[64'h3000] = 32'hCAFEBABE;
        phys[64'h3004] = 32'h0BADF00D;
        phys[64'h3008] = 32'h89ABCDEF;
        phys[64'h300C] = 32'h01234567;

        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_mem_bus", {bus.mem_addr[31:0], bus.mem_wdata},  64'd0);
        chk("rst_mem_be_we", 64'({bus.mem_be, bus.mem_we}), 64'd0);
        #10;
        reset = 1'b1;
        @(posedge clk);

        // Signed byte load, lane 3.
        do_req(1'b0, 64'h1003, 2'b00, 1'b1, 64'h0, 0, 0);
        chk("t1_rdata", got_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_be", 64'(log_be[0]), 64'h8);
        chk("t1_lat", 64'(got_lat), 64'd2);
        chk("t1_err", 64'(got_err), 64'd0);

        // Double store, issued back-to-back.
        do_req(1'b1, 64'h2000, 2'b11, 1'b0, 64'h1122334455667788, 0, 0);
        chk("t2_gap", 64'(m_gap), 64'd1);
        chk("t2_a0", log_addr[0], 64'h2000);
        chk("t2_w0", 64'(log_wd[0]), 64'h55667788);
        chk("t2_be0", 64'(log_be[0]), 64'hF);
        chk("t2_a1", log_addr[1], 64'h2004);
        chk("t2_w1", 64'(log_wd[1]), 64'h11223344);
        chk("t2_lat", 64'(got_lat), 64'd3);
        chk("t2_rdata", got_rdata, 64'd0);

        // Misaligned word load.
        do_req(1'b0, 64'h0002, 2'b10, 1'b0, 64'h0, 0, 0);
        chk("t3_mreq", 64'(mreq_cyc), 64'd0);
        chk("t3_lat", 64'(got_lat), 64'd1);
        chk("t3_err", 64'(got_err), 64'd1);
        chk("t3_rdata", got_rdata, 64'd0);

        // Half unsigned load with 5 wait states.
        do_req(1'b0, 64'h0102, 2'b01, 1'b0, 64'h0, 5, 0);
        chk("t4_mreq", 64'(mreq_cyc), 64'd6);
        chk("t4_rdata", got_rdata, 64'h000000000000F00D);
        chk("t4_lat", 64'(got_lat), 64'd7);

        // Further lane/size/sign patterns.
        do_req(1'b0, 64'h1001, 2'b00, 1'b0, 64'h0, 0, 0);
        chk("byte_u_l1", got_rdata, 64'hBB);
        do_req(1'b0, 64'h1000, 2'b01, 1'b1, 64'h0, 1, 0);
        chk("half_s_l0", got_rdata, 64'hFFFF_FFFF_FFFF_BBCC);
        do_req(1'b0, 64'h1000, 2'b10, 1'b1, 64'h0, 0, 0);
        chk("word_s", got_rdata, 64'hFFFF_FFFF_80AA_BBCC);
        do_req(1'b0, 64'h1000, 2'b10, 1'b0, 64'hDEAD, 2, 0);
        chk("word_u", got_rdata, 64'h0000_0000_80AA_BBCC);
        do_req(1'b0, 64'h3008, 2'b11, 1'b1, 64'h0, 1, 2);
        chk("dbl_load", got_rdata, 64'h0123456789ABCDEF);
        chk("dbl_load_lat", 64'(got_lat), 64'd6);
        do_req(1'b1, 64'h2002, 2'b00, 1'b0, 64'hA5, 0, 0);
        chk("sb_be", 64'(log_be[0]), 64'h4);
        chk("sb_wd", 64'(log_wd[0]), 64'hA5A5A5A5);
        do_req(1'b1, 64'h2002, 2'b01, 1'b0, 64'hBEEF, 3, 0);
        chk("sh_be", 64'(log_be[0]), 64'hC);
        chk("sh_wd", 64'(log_wd[0]), 64'hBEEFBEEF);
        do_req(1'b0, 64'h1001, 2'b01, 1'b1, 64'h0, 0, 0);
        chk("mis_half", 64'(got_err), 64'd1);
        do_req(1'b0, 64'h3004, 2'b11, 1'b0, 64'h0, 0, 0);
        chk("mis_dbl", 64'(got_err), 64'd1);
        do_req(1'b0, 64'h1003, 2'b00, 1'b0, 64'h0, 0, 0);
        chk("byte_u_l3", got_rdata, 64'h80);

        // Reset during the second beat of a double load.
        #1;
        d[0] = 0;
        d[1] = 1000;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 64'h3000;
        bus.req_size = 2'b11;
        bus.req_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        tn = 0;
        while (!(bidx == 1 && bus.mem_req) && tn < 20) begin
            @(posedge clk);
            #1;
            tn++;
        end
        chk("reach_beat1", 64'(bus.mem_req && bidx == 1), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_async_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_async_rsp", 64'(bus.rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        do_req(1'b0, 64'h1002, 2'b00, 1'b1, 64'h0, 0, 0);
        chk("post_rst_load", got_rdata, 64'hFFFF_FFFF_FFFF_FFAA);
        chk("post_rst_lat", 64'(got_lat), 64'd2);

        // Timeout unit: no ack, then ack on the final count.
        t_run(0, tn, tgot, terr, trd);
        chk("to_beats", 64'(tn), 64'd4);
        chk("to_rsp", 64'(tgot), 64'd1);
        chk("to_err", 64'(terr), 64'd1);
        chk("to_rdata", trd, 64'd0);
        @(negedge clk);
        chk("to_ready_next", 64'(t_bus.req_ready), 64'd1);
        t_run(4, tn, tgot, terr, trd);
        chk("ackwin_beats", 64'(tn), 64'd4);
        chk("ackwin_err", 64'(terr), 64'd0);
        chk("ackwin_rdata", trd, 64'h12345678);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
